mem_stage_ctrl: RTL and testbench

Memory-access stage controller sitting directly downstream of the ALU stage. It takes the ALU result as a byte address and the register-file B operand as store data, then runs one load or store per `start` against a data memory with a request/acknowledge handshake. It returns load data (word, or zero-extended byte) to the write-back path and reports `done`/`err` to the multicycle control FSM.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/byte_lane_unit.sv | 34 +++
 rtl/mem_stage_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// byte-enable constants and small byte-lane helpers.
package mips_pkg;

    // Memory-stage controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-enable patterns (little-endian: bit 0 = bits [7:0])
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // One-hot byte enable for a single lane
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            default: be = 4'b1000;
        endcase
        return be;
    endfunction

    // Select one byte of a word by lane
    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // A word access must sit on a 4-byte boundary; byte accesses never fault
    function automatic logic is_misaligned(input logic       byte_op,
                                           input logic [1:0] lane);
        return (!byte_op) && (lane != 2'd0);
    endfunction

endpackage : mips_pkg

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane steering: byte enables and replicated write data
// for stores, and lane extraction with zero-extension for loads.
module byte_lane_unit
    import mips_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        byte_op,
    input  logic [31:0] store_data,
    input  logic [31:0] load_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    // Store side: a byte store writes the same byte into every lane so the
    // memory only has to honour the enables, never shift the data
    always_comb begin
        be    = BE_WORD;
        wdata = store_data;
        if (byte_op) begin
            be    = lane_be(lane);
            wdata = {4{store_data[7:0]}};
        end
    end

    // Load side: byte loads are zero-extended into the low byte
    always_comb begin
        load_data = load_rdata;
        if (byte_op) begin
            load_data = {24'b0, lane_byte(load_rdata, lane)};
        end
    end

endmodule : byte_lane_unit

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage controller. Runs one load or store per start strobe
// against a data memory with a request/acknowledge handshake and reports
// done/err back to the multicycle control FSM.
//
// Handshake: mem_req is a valid-style request; mem_ack is the acknowledge.
// While mem_req=1 the command fields (mem_addr, mem_be, mem_we, mem_wdata)
// are held stable. A transfer completes at the rising edge where mem_req=1
// and mem_ack=1 are both sampled; mem_req drops at that same edge.
// mem_ack seen outside REQ carries no meaning and is ignored.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [31:0]       ALU_MEM_Addr,
    input  logic [31:0]       MEM_DataIn,
    input  logic              MEM_WrEn,
    input  logic              ByteOp,
    output logic [31:0]       MEM_DataOut,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       lane_q;
    logic             byte_q;

    logic [1:0]  lane_sel;
    logic        byte_sel;
    logic [3:0]  lane_be_w;
    logic [31:0] lane_wdata_w;
    logic [31:0] lane_load_w;
    logic        misaligned;

    // Address bits above the word address and the byte offset wrap away
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ALU_MEM_Addr[31:ADDR_W+2]};

    // In IDLE the lane unit steers the incoming command; afterwards it
    // works from the latched lane so load extraction matches the request
    always_comb begin
        lane_sel = lane_q;
        byte_sel = byte_q;
        if (state == IDLE) begin
            lane_sel = ALU_MEM_Addr[1:0];
            byte_sel = ByteOp;
        end
    end

    assign misaligned = is_misaligned(ByteOp, ALU_MEM_Addr[1:0]);
    assign state_dbg  = state;

    byte_lane_unit u_lanes (
        .lane       (lane_sel),
        .byte_op    (byte_sel),
        .store_data (MEM_DataIn),
        .load_rdata (mem_rdata),
        .be         (lane_be_w),
        .wdata      (lane_wdata_w),
        .load_data  (lane_load_w)
    );

    // Control FSM with wait counter; every output is a register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            lane_q      <= 2'd0;
            byte_q      <= 1'b0;
            MEM_DataOut <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= BE_NONE;
            mem_wdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (misaligned) begin
                            // Fault reported without touching the memory
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            wait_cnt  <= '0;
                            lane_q    <= ALU_MEM_Addr[1:0];
                            byte_q    <= ByteOp;
                            mem_req   <= 1'b1;
                            mem_we    <= MEM_WrEn;
                            mem_addr  <= ALU_MEM_Addr[ADDR_W+1:2];
                            mem_be    <= lane_be_w;
                            mem_wdata <= lane_wdata_w;
                        end
                    end
                end

                REQ: begin
                    // Ack takes priority, including on the final timeout cycle
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        if (!mem_we) begin
                            MEM_DataOut <= lane_load_w;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with hand-computed expectations.
module tb_mem_stage_ctrl;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [31:0] ALU_MEM_Addr;
    logic [31:0] MEM_DataIn;
    logic        MEM_WrEn;
    logic        ByteOp;
    logic [31:0] MEM_DataOut;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_ctrl #(.ADDR_W(10), .TIMEOUT(16)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .start        (start),
        .ALU_MEM_Addr (ALU_MEM_Addr),
        .MEM_DataIn   (MEM_DataIn),
        .MEM_WrEn     (MEM_WrEn),
        .ByteOp       (ByteOp),
        .MEM_DataOut  (MEM_DataOut),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge, then settle before sampling
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wd,
                         input logic we, input logic bop);
        ALU_MEM_Addr = addr;
        MEM_DataIn   = wd;
        MEM_WrEn     = we;
        ByteOp       = bop;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, MEM_DataOut, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {31'd0, err}, 32'd0);
        check({tag, "_req"},  {31'd0, mem_req}, 32'd0);
        check({tag, "_we"},   {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, {22'd0, mem_addr}, 32'd0);
        check({tag, "_be"},   {28'd0, mem_be}, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    int req_cycles;

    initial begin
        Reset_n      = 1'b0;
        start        = 1'b0;
        ALU_MEM_Addr = 32'd0;
        MEM_DataIn   = 32'd0;
        MEM_WrEn     = 1'b0;
        ByteOp       = 1'b0;
        mem_rdata    = 32'd0;
        mem_ack      = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        Reset_n = 1'b1;
        tick();

        // Word load, zero-wait
        mem_rdata = 32'hDEADBEEF;
        issue(32'h10, 32'h0, 1'b0, 1'b0);
        check("wl_req",  {31'd0, mem_req}, 32'd1);
        check("wl_busy", {31'd0, busy}, 32'd1);
        check("wl_addr", {22'd0, mem_addr}, 32'd4);
        check("wl_be",   {28'd0, mem_be}, 32'hF);
        check("wl_we",   {31'd0, mem_we}, 32'd0);
        check("wl_done_early", {31'd0, done}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wl_done", {31'd0, done}, 32'd1);
        check("wl_err",  {31'd0, err}, 32'd0);
        check("wl_dout", MEM_DataOut, 32'hDEADBEEF);
        check("wl_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        check("wl_done_pulse", {31'd0, done}, 32'd0);
        check("wl_busy_idle", {31'd0, busy}, 32'd0);

        // Byte store, ack after 3 cycles
        mem_rdata = 32'h99999999;
        issue(32'h13, 32'h000000A5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bs_req",   {31'd0, mem_req}, 32'd1);
            check("bs_be",    {28'd0, mem_be}, 32'h8);
            check("bs_wdata", mem_wdata, 32'hA5A5A5A5);
            check("bs_we",    {31'd0, mem_we}, 32'd1);
            check("bs_addr",  {22'd0, mem_addr}, 32'd4);
            check("bs_nodone", {31'd0, done}, 32'd0);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("bs_done", {31'd0, done}, 32'd1);
        check("bs_err",  {31'd0, err}, 32'd0);
        check("bs_dout_kept", MEM_DataOut, 32'hDEADBEEF);
        tick();

        // Byte load lane 1
        mem_rdata = 32'h11223344;
        issue(32'h21, 32'h0, 1'b0, 1'b1);
        check("bl1_addr", {22'd0, mem_addr}, 32'd8);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("bl1_done", {31'd0, done}, 32'd1);
        check("bl1_dout", MEM_DataOut, 32'h00000033);
        tick();

        // Byte load lane 3
        issue(32'h23, 32'h0, 1'b0, 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("bl3_dout", MEM_DataOut, 32'h00000011);
        tick();

        // Misaligned word store
        issue(32'h6, 32'h12345678, 1'b1, 1'b0);
        check("mis_req",  {31'd0, mem_req}, 32'd0);
        check("mis_done", {31'd0, done}, 32'd1);
        check("mis_err",  {31'd0, err}, 32'd1);
        check("mis_busy", {31'd0, busy}, 32'd1);
        tick();
        check("mis_req2",  {31'd0, mem_req}, 32'd0);
        check("mis_done2", {31'd0, done}, 32'd0);
        check("mis_dout",  MEM_DataOut, 32'h00000011);

        // Timeout with no ack
        mem_rdata = 32'hBADBAD00;
        issue(32'h40, 32'h0, 1'b0, 1'b0);
        req_cycles = 0;
        while (mem_req && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", req_cycles, 32'd16);
        check("to_done", {31'd0, done}, 32'd1);
        check("to_err",  {31'd0, err}, 32'd1);
        check("to_dout", MEM_DataOut, 32'h00000011);
        tick();

        // Ack on the 16th cycle wins; start during REQ is ignored
        issue(32'h44, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            start = (i == 3);
            ALU_MEM_Addr = 32'h80;
            tick();
        end
        start = 1'b0;
        check("ta_req_16", {31'd0, mem_req}, 32'd1);
        check("ta_addr_kept", {22'd0, mem_addr}, 32'd17);
        mem_rdata = 32'hCAFEF00D;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ta_done", {31'd0, done}, 32'd1);
        check("ta_err",  {31'd0, err}, 32'd0);
        check("ta_dout", MEM_DataOut, 32'hCAFEF00D);
        tick();
        check("ta_idle_req", {31'd0, mem_req}, 32'd0);
        check("ta_idle_state", {30'd0, state_dbg}, 32'd0);

        // Reset during REQ
        issue(32'h100, 32'h12345678, 1'b1, 1'b0);
        check("rr_req", {31'd0, mem_req}, 32'd1);
        Reset_n = 1'b0;
        tick();
        check_all_zero("rr");
        Reset_n = 1'b1;
        tick();
        check("rr_nodone", {31'd0, done}, 32'd0);

        // Ack in IDLE is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ia_done", {31'd0, done}, 32'd0);
        check("ia_dout", MEM_DataOut, 32'd0);

        // Upper address bits wrap
        mem_rdata = 32'h0BADF00D;
        issue(32'hFFFFF00C, 32'h0, 1'b0, 1'b0);
        check("wr_addr", {22'd0, mem_addr}, 32'd3);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_dout", MEM_DataOut, 32'h0BADF00D);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
